// File: rtl/morph_frame_ctrl.sv
// Frame sequencer for the morphology path: commits shadowed mode at frame start, pulses a CLR_LEN-cycle datapath clear,
// and checks line/pixel counts. All outputs registered (1-cycle latency from the sampled edge); no backpressure on the video side.
module morph_frame_ctrl #(
  parameter int COL     = 640,
  parameter int ROW     = 480,
  parameter int CLR_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_valid,
  input  logic [1:0]                 cfg_mode,
  output logic                       cfg_ready,
  input  logic                       y_vs,
  input  logic                       y_de,
  output logic                       pipe_rst_n,
  output logic [1:0]                 mode_act,
  output logic                       frame_busy,
  output logic                       frame_done,
  output logic                       frame_err,
  output logic                       err_sticky,
  output logic [$clog2(ROW+1)-1:0]   line_cnt
);

  localparam int LW = $clog2(ROW + 1);
  localparam int PW = $clog2(COL + 2);
  localparam int CW = (CLR_LEN > 1) ? $clog2(CLR_LEN) : 1;

  localparam logic [PW-1:0] P_COL     = PW'(COL);
  localparam logic [PW-1:0] P_COL_SAT = PW'(COL + 1);
  localparam logic [LW-1:0] P_ROW     = LW'(ROW);
  localparam logic [CW-1:0] P_CLR     = CW'(CLR_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_ACTIVE, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_vs, r_de;
  logic [CW-1:0]   r_clr_cnt, w_clr_nxt;
  logic [PW-1:0]   r_pix_cnt, w_pix_nxt;
  logic [LW-1:0]   r_line_cnt, w_line_nxt;
  logic [1:0]      r_shadow, w_shadow_nxt;
  logic            r_shadow_full, w_full_nxt;
  logic [1:0]      r_mode_act, w_mode_nxt;
  logic            r_cfg_ready;
  logic            r_pipe_rst_n, w_pipe_nxt;
  logic            r_busy;
  logic            r_done, w_done_nxt;
  logic            r_err, w_err_nxt;
  logic            r_sticky;

  logic            w_vs_rise, w_de_fall, w_acc;

  assign w_vs_rise = y_vs & ~r_vs;
  assign w_de_fall = ~y_de & r_de;
  assign w_acc     = cfg_valid & r_cfg_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_clr_nxt    = r_clr_cnt;
    w_pix_nxt    = r_pix_cnt;
    w_line_nxt   = r_line_cnt;
    w_pipe_nxt   = 1'b1;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_mode_nxt   = r_mode_act;
    w_shadow_nxt = r_shadow;
    w_full_nxt   = r_shadow_full;

    if (w_acc) begin
      w_shadow_nxt = cfg_mode;
      w_full_nxt   = 1'b1;
    end

    if (w_vs_rise) begin
      w_state_nxt = S_CLEAR;
      w_clr_nxt   = P_CLR;
      w_pipe_nxt  = 1'b0;
      w_pix_nxt   = '0;
      w_line_nxt  = '0;
      w_err_nxt   = (r_state == S_ACTIVE);
      // Old shadow commits; a request accepted this same cycle stays parked for the next frame.
      if (r_shadow_full) begin
        w_mode_nxt = (r_shadow == 2'b11) ? 2'b00 : r_shadow;
        w_full_nxt = w_acc;
      end
    end else begin
      case (r_state)
        S_CLEAR: begin
          w_err_nxt = y_de;
          if (r_clr_cnt == '0) begin
            w_state_nxt = S_ACTIVE;
          end else begin
            w_clr_nxt  = r_clr_cnt - 1'b1;
            w_pipe_nxt = 1'b0;
          end
        end
        S_ACTIVE: begin
          if (w_de_fall) begin
            w_err_nxt  = (r_pix_cnt != P_COL);
            w_pix_nxt  = '0;
            w_line_nxt = r_line_cnt + 1'b1;
            if (w_line_nxt == P_ROW) begin
              w_done_nxt  = ~w_err_nxt;
              w_state_nxt = S_DONE;
            end
          end else if (y_de && (r_pix_cnt != P_COL_SAT)) begin
            w_pix_nxt = r_pix_cnt + 1'b1;
          end
        end
        S_DONE:  w_err_nxt = w_de_fall;
        S_IDLE:  w_err_nxt = 1'b0;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_vs          <= 1'b1;
      r_de          <= 1'b0;
      r_clr_cnt     <= '0;
      r_pix_cnt     <= '0;
      r_line_cnt    <= '0;
      r_shadow      <= 2'b00;
      r_shadow_full <= 1'b0;
      r_mode_act    <= 2'b00;
      r_cfg_ready   <= 1'b1;
      r_pipe_rst_n  <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_sticky      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_vs          <= y_vs;
      r_de          <= y_de;
      r_clr_cnt     <= w_clr_nxt;
      r_pix_cnt     <= w_pix_nxt;
      r_line_cnt    <= w_line_nxt;
      r_shadow      <= w_shadow_nxt;
      r_shadow_full <= w_full_nxt;
      r_mode_act    <= w_mode_nxt;
      r_cfg_ready   <= ~r_shadow_full;
      r_pipe_rst_n  <= w_pipe_nxt;
      r_busy        <= (w_state_nxt == S_CLEAR) || (w_state_nxt == S_ACTIVE);
      r_done        <= w_done_nxt;
      r_err         <= w_err_nxt;
      r_sticky      <= w_err_nxt | (r_sticky & ~w_acc);
    end
  end

  assign cfg_ready  = r_cfg_ready;
  assign pipe_rst_n = r_pipe_rst_n;
  assign mode_act   = r_mode_act;
  assign frame_busy = r_busy;
  assign frame_done = r_done;
  assign frame_err  = r_err;
  assign err_sticky = r_sticky;
  assign line_cnt   = r_line_cnt;

endmodule

// File: tb/tb_morph_frame_ctrl.sv
// Bench for morph_frame_ctrl with COL=8, ROW=4, CLR_LEN=4: directed frames, frame_done/frame_err events scoreboarded.
module tb_morph_frame_ctrl;

  logic       clk, rst_n, cfg_valid, cfg_ready, y_vs, y_de;
  logic [1:0] cfg_mode, mode_act;
  logic       pipe_rst_n, frame_busy, frame_done, frame_err, err_sticky;
  logic [2:0] line_cnt;

  morph_frame_ctrl #(.COL(8), .ROW(4), .CLR_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_ready(cfg_ready),
    .y_vs(y_vs), .y_de(y_de), .pipe_rst_n(pipe_rst_n), .mode_act(mode_act), .frame_busy(frame_busy),
    .frame_done(frame_done), .frame_err(frame_err), .err_sticky(err_sticky), .line_cnt(line_cnt)
  );

  typedef struct packed {
    logic       done;
    logic       err;
    logic [2:0] lines;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   acc_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every frame_done/frame_err pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && (frame_done || frame_err)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {frame_done, frame_err}, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ev_done", frame_done, e.done);
        chk("ev_err", frame_err, e.err);
        chk("ev_lines", line_cnt, e.lines);
      end
    end
  end

  // Acts as a well-behaved cfg master: drops valid after an accepted edge.
  task automatic tick();
    logic acc;
    acc = cfg_valid & cfg_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      cfg_valid = 1'b0;
      acc_cnt++;
    end
  endtask

  task automatic push(input logic d, input logic e, input int l);
    exp_t x;
    x.done  = d;
    x.err   = e;
    x.lines = 3'(l);
    exp_q.push_back(x);
  endtask

  task automatic start_frame(input logic [1:0] m);
    int low;
    y_vs = 1'b1;
    tick();
    y_vs = 1'b0;
    chk("mode_act_at_E1", mode_act, m);
    chk("busy_at_E1", frame_busy, 1);
    chk("line_cnt_zeroed", line_cnt, 0);
    low = 0;
    for (int i = 0; i < 7; i++) begin
      if (!pipe_rst_n) low++;
      tick();
    end
    chk("pipe_rst_low_cycles", low, 4);
    chk("pipe_rst_released", pipe_rst_n, 1);
  endtask

  task automatic send_line(input int npx);
    for (int i = 0; i < npx; i++) begin
      y_de = 1'b1;
      tick();
    end
    y_de = 1'b0;
    tick();
    tick();
  endtask

  task automatic run_lines(input int nlines, input int short_idx);
    for (int l = 1; l <= nlines; l++) begin
      if (l == short_idx) push(1'b0, 1'b1, l);
      else if (l == 4)    push(1'b1, 1'b0, l);
      send_line((l == short_idx) ? 7 : 8);
    end
  endtask

  task automatic cfg_send(input logic [1:0] m);
    cfg_valid = 1'b1;
    cfg_mode  = m;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_mode = 2'b00; y_vs = 1'b0; y_de = 1'b0;
    #12;
    chk("rst_pipe_rst_n", pipe_rst_n, 1);
    chk("rst_mode_act", mode_act, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", frame_busy, 0);
    chk("rst_done_err", {frame_done, frame_err}, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_line_cnt", line_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();

    // Clean frame
    start_frame(2'b00);
    run_lines(4, 0);
    chk("clean_line_cnt", line_cnt, 4);
    chk("clean_sticky", err_sticky, 0);
    chk("clean_busy_done", frame_busy, 0);

    // Short line 2
    start_frame(2'b00);
    run_lines(4, 2);
    chk("short_sticky", err_sticky, 1);

    // Mid-frame config, stalled second request, then restart after 2 lines
    start_frame(2'b00);
    run_lines(1, 0);
    cfg_send(2'b01);
    chk("accept_clears_sticky", err_sticky, 0);
    tick();
    chk("cfg_ready_low_full", cfg_ready, 0);
    chk("mode_held_midframe", mode_act, 0);
    run_lines(1, 0);
    cfg_valid = 1'b1;
    cfg_mode  = 2'b10;
    tick(); tick();
    chk("second_req_stalled_rdy", cfg_ready, 0);
    chk("second_req_stalled_cnt", acc_cnt, 1);
    push(1'b0, 1'b1, 0);
    start_frame(2'b01);
    chk("second_req_after_commit", acc_cnt, 2);
    run_lines(4, 0);

    // Extra line after the frame completed
    push(1'b0, 1'b1, 4);
    send_line(8);
    chk("done_line_cnt_hold", line_cnt, 4);

    start_frame(2'b10);
    run_lines(4, 0);

    // Accept on the same edge as vs_rise, with 01 already in the shadow
    cfg_send(2'b01);
    cfg_valid = 1'b1;
    cfg_mode  = 2'b10;
    start_frame(2'b01);
    chk("simul_accepts", acc_cnt, 4);
    chk("simul_shadow_full", cfg_ready, 0);
    run_lines(4, 0);
    start_frame(2'b10);
    run_lines(4, 0);

    // Reserved mode commits as bypass
    cfg_send(2'b11);
    tick(); tick();
    start_frame(2'b00);

    // Asynchronous reset mid-ACTIVE
    cfg_send(2'b01);
    run_lines(1, 1);
    chk("pre_rst_sticky", err_sticky, 1);
    chk("pre_rst_busy", frame_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", frame_busy, 0);
    chk("arst_line_cnt", line_cnt, 0);
    chk("arst_sticky", err_sticky, 0);
    chk("arst_cfg_ready", cfg_ready, 1);
    chk("arst_pipe", pipe_rst_n, 1);
    y_vs = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("vs_high_rel_no_busy", frame_busy, 0);
      chk("vs_high_rel_no_clear", pipe_rst_n, 1);
    end
    y_vs = 1'b0;
    tick();
    start_frame(2'b00);
    run_lines(4, 0);

    tick(); tick();
    chk("pending_events", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
